// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte serializer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

  localparam int SpiBitsPerByte    = 8;
  localparam int SpiEdgesPerByte   = 16;
  localparam int SpiClkDivDefault  = 2;

endpackage

// File: rtl/spi_shifter_if.sv
// Byte-side handshake between the TX/RX FIFOs and the SPI serializer.
// slave = serializer side, master = FIFO/register-block side.
interface spi_shifter_if;
  logic       start_i;
  logic [7:0] byte_data_i;
  logic       next_tx_byte_o;
  logic [7:0] byte_data_o;
  logic       byte_valid_o;
  logic       busy_o;

  modport slave (
    input  start_i, byte_data_i,
    output next_tx_byte_o, byte_data_o, byte_valid_o, busy_o
  );

  modport master (
    output start_i, byte_data_i,
    input  next_tx_byte_o, byte_data_o, byte_valid_o, busy_o
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period down-counter that toggles sck on terminal count
// and flags whether that toggle is the leading or trailing edge of the pulse.
module spi_sck_gen import spi_pkg::*; #(
  parameter int CLK_DIV = SpiClkDivDefault,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic lead_stb_o,
  output logic trail_stb_o
);

  localparam int CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            tick;

  assign tick = en_i && (cnt_q == '0);

  // Counter parks at the reload value while disabled so the first edge
  // lands exactly CLK_DIV cycles after enable rises.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i || tick) cnt_d = Reload;
    else               cnt_d = cnt_q - CntW'(1);
    if (tick) sck_d = ~sck_q;
  end

  // Counter and SCK registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= CPOL;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign lead_stb_o  = tick && (sck_q == CPOL);
  assign trail_stb_o = tick && (sck_q != CPOL);

endmodule

// File: rtl/spi_shifter.sv
// SPI master byte serializer fed by the TX FIFO.
// Optional build macro SPI_SHIFTER_LOOPBACK_EN: sample the driven spi_tx_o
// instead of spi_rx_i, so the received byte mirrors the transmitted one.
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | pop FIFO head, preload tx shifter (1 cycle)
// SHIFT | run 16 SCK edges, shift out / sample in
// DONE  | publish received byte with byte_valid_o (1 cycle)
module spi_shifter import spi_pkg::*; #(
  parameter int CLK_DIV = SpiClkDivDefault,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spi_shifter_if.slave    bus,
  input  logic            spi_rx_i,
  output logic            spi_tx_o,
  output logic            sck_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;
  localparam logic [4:0] EdgesLast = 5'(SpiEdgesPerByte);
  localparam logic [3:0] BitsLast  = 4'(SpiBitsPerByte);

  logic [1:0] state_q, state_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic       tx_q, tx_d;

  logic       sck_en, lead_stb, trail_stb, sample_stb, shift_stb;
  logic       tx_out, rx_src;
  logic [7:0] tx_src;

  assign sck_en = (state_q == S_LOAD) ||
                  ((state_q == S_SHIFT) && (edge_cnt_q != EdgesLast));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sck_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (sck_en),
    .sck_o       (sck_o),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb)
  );

  assign sample_stb = CPHA ? trail_stb : lead_stb;
  assign shift_stb  = CPHA ? lead_stb  : trail_stb;

  // Mode 0/2 must show bit 7 already during LOAD, since with CLK_DIV = 1
  // the first sample edge follows immediately.
  assign tx_out = ((state_q == S_LOAD) && !CPHA) ? bus.byte_data_i[7] : tx_q;
  assign tx_src = (state_q == S_LOAD) ? bus.byte_data_i : tx_sh_q;

`ifdef SPI_SHIFTER_LOOPBACK_EN
  logic unused_spi_rx;
  assign unused_spi_rx = spi_rx_i;
  assign rx_src        = tx_out;
`else
  assign rx_src = spi_rx_i;
`endif

  // Next-state logic: FSM plus per-edge shift/sample actions.
  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    bit_cnt_d  = bit_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;

    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_LOAD;
      S_LOAD: begin
        tx_sh_d    = bus.byte_data_i;
        bit_cnt_d  = '0;
        edge_cnt_d = '0;
        if (!CPHA) tx_d = bus.byte_data_i[7];
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (edge_cnt_q == EdgesLast) begin
          rx_byte_d = rx_sh_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = bus.start_i ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (lead_stb || trail_stb) edge_cnt_d = edge_cnt_d + 5'd1;

    // Once all 8 bits are sampled the final trailing edge in modes 0/2 has
    // no next bit, so spi_tx_o keeps bit 0.
    if (shift_stb && (bit_cnt_d < BitsLast)) begin
      if (CPHA) begin
        tx_d    = tx_src[7];
        tx_sh_d = {tx_src[6:0], 1'b0};
      end else begin
        tx_d    = tx_sh_q[6];
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end
    end

    if (sample_stb) begin
      rx_sh_d   = {rx_sh_q[6:0], rx_src};
      bit_cnt_d = bit_cnt_d + 4'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      bit_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      bit_cnt_q  <= bit_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign spi_tx_o           = tx_out;
  assign bus.next_tx_byte_o = (state_q == S_LOAD);
  assign bus.byte_valid_o   = (state_q == S_DONE);
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.byte_data_o    = rx_byte_q;

endmodule
